// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back, write-allocate data cache
// One-word lines, true LRU through per-way ages, registered CPU and memory outputs.
module set_assoc_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 2,
  parameter int WAYS          = 2,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cpu_req_i,
  input  logic                     cpu_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
  output logic                     cpu_done_o,
  output logic                     mem_req_o,
  output logic                     mem_wen_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i,
  output logic [COUNTER_WIDTH-1:0] hit_count_o,
  output logic [COUNTER_WIDTH-1:0] miss_count_o
);
  localparam int SETS      = 1 << SET_WIDTH;
  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int WAY_W     = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-3:0] addr_q;
  logic                     wen_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [WAY_W-1:0]         victim_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAY_W-1:0]      age_q   [SETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  logic                     done_q, mem_req_q, mem_wen_q;
  logic [DATA_WIDTH-1:0]    rdata_q, mem_wdata_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [COUNTER_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  logic [SET_WIDTH-1:0] set_idx;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 ack, unused_addr_lsbs;
  logic                 hit, vic_found;
  logic [WAY_W-1:0]     hit_way, vic_way;

  logic                  touch_en, install_en, install_dirty, wr_hit_en, inv_en, hit_inc, miss_inc;
  logic [WAY_W-1:0]      touch_way, install_way;
  logic [DATA_WIDTH-1:0] install_data;

  assign set_idx          = addr_q[SET_WIDTH-1:0];
  assign req_tag          = addr_q[ADDRESS_WIDTH-3:SET_WIDTH];
  assign ack              = mem_ack_i & mem_req_q;
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    touch_en      = 1'b0;
    touch_way     = hit_way;
    install_en    = 1'b0;
    install_way   = victim_q;
    install_dirty = 1'b1;
    install_data  = wdata_q;
    wr_hit_en     = 1'b0;
    inv_en        = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state_q)
      IDLE: if (cpu_req_i && !done_q) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          hit_inc   = 1'b1;
          touch_en  = 1'b1;
          wr_hit_en = wen_q;
          state_d   = RESPOND;
        end else begin
          miss_inc = 1'b1;
          if (valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way]) begin
            state_d = WRITEBACK;
          end else if (wen_q) begin
            install_en  = 1'b1;
            install_way = vic_way;
            touch_en    = 1'b1;
            touch_way   = vic_way;
            state_d     = RESPOND;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        if (ack) begin
          inv_en = 1'b1;
          if (wen_q) begin
            install_en = 1'b1;
            touch_en   = 1'b1;
            touch_way  = victim_q;
            state_d    = RESPOND;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (ack) begin
          install_en    = 1'b1;
          install_dirty = 1'b0;
          install_data  = mem_rdata_i;
          touch_en      = 1'b1;
          touch_way     = victim_q;
          state_d       = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == RESPOND);
      if (state_q == IDLE && state_d == LOOKUP) begin
        addr_q  <= cpu_addr_i[ADDRESS_WIDTH-1:2];
        wen_q   <= cpu_wen_i;
        wdata_q <= cpu_wdata_i;
      end
      if (miss_inc) victim_q <= vic_way;
      if (state_q == LOOKUP && hit && !wen_q) rdata_q <= data_q[set_idx][hit_way];
      if (state_q == FILL && ack) rdata_q <= mem_rdata_i;
      // Memory outputs only move on entry to a memory state, or drop after the ack.
      if (state_d == WRITEBACK && state_q != WRITEBACK) begin
        mem_req_q   <= 1'b1;
        mem_wen_q   <= 1'b1;
        mem_addr_q  <= {tag_q[set_idx][vic_way], set_idx, 2'b00};
        mem_wdata_q <= data_q[set_idx][vic_way];
      end else if (state_d == FILL && state_q != FILL) begin
        mem_req_q  <= 1'b1;
        mem_wen_q  <= 1'b0;
        mem_addr_q <= {addr_q, 2'b00};
      end else if (ack) begin
        mem_req_q <= 1'b0;
      end
      if (hit_inc && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      if (inv_en) valid_q[set_idx][victim_q] <= 1'b0;
      if (install_en) begin
        valid_q[set_idx][install_way] <= 1'b1;
        dirty_q[set_idx][install_way] <= install_dirty;
      end
      if (wr_hit_en) dirty_q[set_idx][hit_way] <= 1'b1;
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[set_idx][w] < age_q[set_idx][touch_way])
            age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
        end
        age_q[set_idx][touch_way] <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (install_en) begin
      tag_q[set_idx][install_way]  <= req_tag;
      data_q[set_idx][install_way] <= install_data;
    end
    if (wr_hit_en) data_q[set_idx][hit_way] <= wdata_q;
  end

  assign cpu_done_o   = done_q;
  assign cpu_rdata_o  = rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - scoreboard bench for set_assoc_cache
// Instance 0: 2 ways, 16-bit counters. Instance 1: 4 ways, 2-bit counters.
module tb_set_assoc_cache;
  logic clk, rst;
  logic        cpu_req [2];
  logic        cpu_wen [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_done [2];
  logic        mem_req [2];
  logic        mem_wen [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        mem_ack [2];
  logic [15:0] hit0, miss0;
  logic [1:0]  hit1, miss1;

  typedef struct {int d; bit is_load; logic [31:0] rdata;} cpu_exp_t;
  typedef struct {int d; bit wen; logic [31:0] addr; logic [31:0] data;} mem_exp_t;
  cpu_exp_t cq[$];
  mem_exp_t mq[$];
  logic [31:0] mem_model [2][64];
  int total = 0;
  int bad = 0;
  int ack_delay = 2;
  int lat;

  set_assoc_cache #(.WAYS(2), .COUNTER_WIDTH(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req[0]), .cpu_wen_i(cpu_wen[0]),
    .cpu_addr_i(cpu_addr[0]), .cpu_wdata_i(cpu_wdata[0]), .cpu_rdata_o(cpu_rdata[0]),
    .cpu_done_o(cpu_done[0]), .mem_req_o(mem_req[0]), .mem_wen_o(mem_wen[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
    .mem_ack_i(mem_ack[0]), .hit_count_o(hit0), .miss_count_o(miss0));

  set_assoc_cache #(.WAYS(4), .COUNTER_WIDTH(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req[1]), .cpu_wen_i(cpu_wen[1]),
    .cpu_addr_i(cpu_addr[1]), .cpu_wdata_i(cpu_wdata[1]), .cpu_rdata_o(cpu_rdata[1]),
    .cpu_done_o(cpu_done[1]), .mem_req_o(mem_req[1]), .mem_wen_o(mem_wen[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
    .mem_ack_i(mem_ack[1]), .hit_count_o(hit1), .miss_count_o(miss1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pm(input int d, input bit wen, input logic [31:0] addr, input logic [31:0] data);
    mem_exp_t e;
    e.d = d; e.wen = wen; e.addr = addr; e.data = data;
    mq.push_back(e);
  endtask

  task automatic cpu_op(input int d, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, output int l);
    cpu_exp_t e;
    e.d = d; e.is_load = !wen; e.rdata = exp_rd;
    cq.push_back(e);
    @(negedge clk);
    cpu_wen[d] = wen; cpu_addr[d] = addr; cpu_wdata[d] = wdata; cpu_req[d] = 1'b1;
    l = 0;
    while (1) begin
      @(negedge clk);
      l++;
      if (cpu_done[d]) break;
      if (l >= 200) begin
        total++; bad++;
        $display("FAIL done_timeout dut=%0d addr=%h got no done expected done", d, addr);
        break;
      end
    end
    cpu_req[d] = 1'b0;
  endtask

  task automatic ld(input int d, input logic [31:0] addr, input logic [31:0] exp_rd);
    int l;
    cpu_op(d, 1'b0, addr, 32'h0, exp_rd, l);
    lat = l;
  endtask

  task automatic st(input int d, input logic [31:0] addr, input logic [31:0] data);
    int l;
    cpu_op(d, 1'b1, addr, data, 32'h0, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) cpu_req[d] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // CPU-side monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : cpu_mon
    cpu_exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (cpu_done[d] === 1'b1) begin
        total++;
        if (cq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected dut=%0d got done expected none", d);
        end else begin
          e = cq.pop_front();
          if (e.d != d || (e.is_load && cpu_rdata[d] !== e.rdata)) begin
            bad++;
            $display("FAIL cpu_resp dut=%0d got rdata %h expected dut=%0d rdata %h",
                     d, cpu_rdata[d], e.d, e.rdata);
          end
        end
      end
    end
  end

  // Memory responder: acks after ack_delay request cycles and checks each transaction.
  initial begin : mem_resp
    int cnt [2];
    mem_exp_t e;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      mem_ack[d] = 1'b0; mem_rdata[d] = '0; cnt[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (mem_ack[d]) begin
          mem_ack[d] = 1'b0;
          cnt[d] = 0;
        end else if (mem_req[d]) begin
          cnt[d]++;
          if (cnt[d] >= ack_delay) begin
            a = mem_addr[d];
            total++;
            if (mq.size() == 0) begin
              bad++;
              $display("FAIL mem_unexpected dut=%0d got wen=%0d addr=%h expected none", d, mem_wen[d], a);
            end else begin
              e = mq.pop_front();
              if (e.d != d || e.wen != mem_wen[d] || e.addr != a || (e.wen && e.data != mem_wdata[d])) begin
                bad++;
                $display("FAIL mem_xact dut=%0d got wen=%0d addr=%h data=%h expected dut=%0d wen=%0d addr=%h data=%h",
                         d, mem_wen[d], a, mem_wdata[d], e.d, e.wen, e.addr, e.data);
              end
            end
            if (mem_wen[d]) mem_model[d][a[7:2]] = mem_wdata[d];
            else mem_rdata[d] = mem_model[d][a[7:2]];
            mem_ack[d] = 1'b1;
          end
        end else begin
          cnt[d] = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; cpu_wen[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      for (int i = 0; i < 64; i++) mem_model[d][i] = 32'h1000_0000 | (i << 2);
    end
    mem_model[0][4] = 32'hDEADBEEF;
    #12;
    check("rst_done", {31'b0, cpu_done[0]}, 32'h0);
    check("rst_rdata", cpu_rdata[0], 32'h0);
    check("rst_mem_req", {31'b0, mem_req[0]}, 32'h0);
    check("rst_mem_addr", mem_addr[0], 32'h0);
    check("rst_counts", {hit0, miss0}, 32'h0);
    check("rst_dut1", {28'b0, hit1, miss1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load miss, then a hit.
    pm(0, 1'b0, 32'h10, 0);
    ld(0, 32'h10, 32'hDEADBEEF);
    check("miss_fill_latency", lat, 4);
    check("miss_count_1", {16'b0, miss0}, 1);
    ld(0, 32'h10, 32'hDEADBEEF);
    check("hit_latency", lat, 2);
    check("hit_count_1", {16'b0, hit0}, 1);
    st(0, 32'h20, 32'h0000_1234);
    ld(0, 32'h20, 32'h0000_1234);
    check("counts_after_store", {hit0, miss0}, {16'd2, 16'd2});

    // Clean victim: LRU chooses 0x10, single fill at 0x20.
    do_reset();
    pm(0, 1'b0, 32'h00, 0); ld(0, 32'h00, 32'h1000_0000);
    pm(0, 1'b0, 32'h10, 0); ld(0, 32'h10, 32'hDEADBEEF);
    ld(0, 32'h00, 32'h1000_0000);
    pm(0, 1'b0, 32'h20, 0); ld(0, 32'h20, 32'h1000_0020);
    pm(0, 1'b0, 32'h10, 0); ld(0, 32'h10, 32'hDEADBEEF);
    check("lru_counts", {hit0, miss0}, {16'd1, 16'd4});

    // Dirty victims: write-back before fill, and write-back then direct store install.
    do_reset();
    st(0, 32'h00, 32'hA);
    st(0, 32'h10, 32'hB);
    pm(0, 1'b1, 32'h00, 32'hA); pm(0, 1'b0, 32'h20, 0);
    ld(0, 32'h20, 32'h1000_0020);
    ld(0, 32'h10, 32'hB);
    st(0, 32'h00, 32'hC);
    pm(0, 1'b1, 32'h10, 32'hB);
    st(0, 32'h20, 32'hD);
    pm(0, 1'b1, 32'h00, 32'hC); pm(0, 1'b0, 32'h10, 0);
    ld(0, 32'h10, 32'hB);
    check("wb_counts", {hit0, miss0}, {16'd1, 16'd6});

    // Reset during a slow write-back abandons it.
    ack_delay = 5;
    do_reset();
    st(0, 32'h00, 32'hA);
    st(0, 32'h10, 32'hB);
    @(negedge clk);
    cpu_wen[0] = 1'b0; cpu_addr[0] = 32'h20; cpu_req[0] = 1'b1;
    for (int i = 0; i < 20 && !mem_req[0]; i++) @(negedge clk);
    check("wb_req_up", {31'b0, mem_req[0]}, 32'h1);
    check("wb_wen", {31'b0, mem_wen[0]}, 32'h1);
    check("wb_addr", mem_addr[0], 32'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_drops_req", {31'b0, mem_req[0]}, 32'h0);
    cpu_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    ack_delay = 2;
    pm(0, 1'b0, 32'h00, 0);
    ld(0, 32'h00, 32'hC);
    check("post_abort_miss", {16'b0, miss0}, 1);

    // Saturating hit counter on the 2-bit instance.
    do_reset();
    pm(1, 1'b0, 32'h04, 0);
    ld(1, 32'h04, 32'h1000_0004);
    for (int i = 0; i < 5; i++) ld(1, 32'h04, 32'h1000_0004);
    check("hit_saturate", {30'b0, hit1}, 3);
    check("miss_unchanged", {30'b0, miss1}, 1);

    // 4-way LRU: fill set 1, touch ways 3,1,0; way 2 (0x24) is evicted.
    do_reset();
    st(1, 32'h04, 32'h1);
    st(1, 32'h14, 32'h2);
    st(1, 32'h24, 32'h3);
    st(1, 32'h34, 32'h4);
    ld(1, 32'h34, 32'h4);
    ld(1, 32'h14, 32'h2);
    ld(1, 32'h04, 32'h1);
    pm(1, 1'b1, 32'h24, 32'h3); pm(1, 1'b0, 32'h44, 0);
    ld(1, 32'h44, 32'h1000_0044);
    check("miss_saturate", {30'b0, miss1}, 3);

    repeat (10) @(negedge clk);
    check("cpu_queue_empty", cq.size(), 0);
    check("mem_queue_empty", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
